board_dropsim_seq: RTL and testbench

//  Parametrised, multi-cycle successor to the single-cycle drop simulator for the falling-block game engine.

---
 rtl/board_dropsim_seq_if.sv | 32 +++
 rtl/board_dropsim_seq.sv | 252 +++++++++++++++++++++++++
 tb/tb_board_dropsim_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/board_dropsim_seq_if.sv
// Request/response bundle for the drop simulator.
// master: move-search side (drives req_*, rsp_ready); slave: simulator.
interface board_dropsim_seq_if #(
    parameter int ROWS  = 20,
    parameter int COLS  = 10,
    parameter int ROW_W = 5,
    parameter int COL_W = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic [15:0]            req_piece;
    logic [COL_W-1:0]       req_col;
    logic [ROWS*COLS-1:0]   req_board;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic                   rsp_ok;
    logic [ROWS*COLS-1:0]   rsp_board;
    logic [ROW_W-1:0]       rsp_land_row;
    logic [2:0]             rsp_lines;

    modport master (
        output req_valid, req_piece, req_col, req_board, rsp_ready,
        input  req_ready, rsp_valid, rsp_ok, rsp_board,
        input  rsp_land_row, rsp_lines
    );

    modport slave (
        input  req_valid, req_piece, req_col, req_board, rsp_ready,
        output req_ready, rsp_valid, rsp_ok, rsp_board,
        output rsp_land_row, rsp_lines
    );
endinterface

// File: rtl/board_dropsim_seq.sv
// Multi-cycle drop simulator: drops a 4x4 piece into a board column,
// places it at its resting row, clears full rows and returns the result.
// Ports: clk, rst_n (async active-low), bus (slave side of
// board_dropsim_seq_if: req_* valid/ready in, rsp_* valid/ready out).
module board_dropsim_seq #(
    parameter int ROWS  = 20,
    parameter int COLS  = 10,
    parameter int ROW_W = 5,
    parameter int COL_W = 4
) (
    input logic clk,
    input logic rst_n,
    board_dropsim_seq_if.slave bus
);

    localparam int BW = ROWS * COLS;
    localparam int YW = ROW_W + 2;
    // Wide enough that a nibble shifted by any column value keeps all bits,
    // so out-of-range cells are visible above bit COLS-1.
    localparam int PW = COLS + 4 + (1 << COL_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SCAN,
        S_PLACE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [15:0]      piece_q;
    logic [COL_W-1:0] col_q;
    logic [BW-1:0]    board_q;
    logic [BW-1:0]    nb_q;
    logic [ROW_W-1:0] y_q;
    logic [ROW_W-1:0] land_q;
    logic [ROW_W-1:0] rd_q;
    logic [ROW_W-1:0] wr_q;
    logic             ok_q;
    logic [2:0]       lines_q;
    logic [ROW_W-1:0] land_out_q;

    logic             illegal;
    logic             coll_y;
    logic             scan_end;
    logic [BW-1:0]    placed;
    logic [COLS-1:0]  cur_row;
    logic             row_full;
    logic [BW-1:0]    nb_wr;

    function automatic logic [COLS-1:0] row_of(
        input logic [BW-1:0] b,
        input logic [YW-1:0] r
    );
        logic [COLS-1:0] v;
        v = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (r == YW'(i)) v = b[i*COLS +: COLS];
        end
        return v;
    endfunction

    function automatic logic [BW-1:0] put_row(
        input logic [BW-1:0]    b,
        input logic [ROW_W-1:0] r,
        input logic [COLS-1:0]  v
    );
        logic [BW-1:0] o;
        o = b;
        for (int i = 0; i < ROWS; i++) begin
            if (r == ROW_W'(i)) o[i*COLS +: COLS] = v;
        end
        return o;
    endfunction

    function automatic logic out_of_bounds(
        input logic [15:0]      p,
        input logic [COL_W-1:0] c
    );
        logic [PW-1:0] acc;
        acc = '0;
        for (int pr = 0; pr < 4; pr++) begin
            acc = acc | (PW'(p[pr*4 +: 4]) << c);
        end
        return |acc[PW-1:COLS];
    endfunction

    function automatic logic collide_at(
        input logic [BW-1:0]    b,
        input logic [15:0]      p,
        input logic [COL_W-1:0] c,
        input logic [YW-1:0]    y
    );
        logic [YW-1:0] r;
        logic [PW-1:0] pw;
        logic          hit;
        hit = 1'b0;
        for (int pr = 0; pr < 4; pr++) begin
            r  = y + YW'(pr);
            pw = PW'(p[pr*4 +: 4]) << c;
            if (p[pr*4 +: 4] != 4'd0) begin
                if (r >= YW'(ROWS)) begin
                    hit = 1'b1;
                end else if (|(pw[COLS-1:0] & row_of(b, r))) begin
                    hit = 1'b1;
                end
            end
        end
        return hit;
    endfunction

    function automatic logic [BW-1:0] place_piece(
        input logic [BW-1:0]    b,
        input logic [15:0]      p,
        input logic [COL_W-1:0] c,
        input logic [ROW_W-1:0] land
    );
        logic [BW-1:0] o;
        logic [YW-1:0] r;
        logic [PW-1:0] pw;
        o = b;
        for (int pr = 0; pr < 4; pr++) begin
            r  = {2'b00, land} + YW'(pr);
            pw = PW'(p[pr*4 +: 4]) << c;
            for (int i = 0; i < ROWS; i++) begin
                if (r == YW'(i)) begin
                    o[i*COLS +: COLS] = o[i*COLS +: COLS] | pw[COLS-1:0];
                end
            end
        end
        return o;
    endfunction

    always_comb begin
        illegal = (piece_q == 16'd0)
               || out_of_bounds(piece_q, col_q)
               || collide_at(board_q, piece_q, col_q, '0);
        coll_y   = collide_at(board_q, piece_q, col_q, {2'b00, y_q});
        scan_end = coll_y || (y_q == ROW_W'(ROWS - 1));
        placed   = place_piece(board_q, piece_q, col_q, land_q);
        cur_row  = row_of(board_q, {2'b00, rd_q});
        row_full = &cur_row;
        nb_wr    = put_row(nb_q, wr_q, cur_row);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        unique case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_n = S_CHECK;
            end
            S_CHECK: begin
                state_n = illegal ? S_DONE : S_SCAN;
            end
            S_SCAN: begin
                if (scan_end) state_n = S_PLACE;
            end
            S_PLACE: begin
                state_n = S_CLEAR;
            end
            S_CLEAR: begin
                if (rd_q == '0) state_n = S_DONE;
            end
            S_DONE: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            piece_q    <= '0;
            col_q      <= '0;
            board_q    <= '0;
            nb_q       <= '0;
            y_q        <= '0;
            land_q     <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            ok_q       <= 1'b0;
            lines_q    <= '0;
            land_out_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        piece_q    <= bus.req_piece;
                        col_q      <= bus.req_col;
                        board_q    <= bus.req_board;
                        ok_q       <= 1'b0;
                        lines_q    <= '0;
                        land_out_q <= '0;
                    end
                end
                S_CHECK: begin
                    y_q <= ROW_W'(1);
                    if (illegal) nb_q <= board_q;
                end
                S_SCAN: begin
                    if (coll_y) begin
                        land_q <= y_q - ROW_W'(1);
                    end else if (scan_end) begin
                        land_q <= y_q;
                    end else begin
                        y_q <= y_q + ROW_W'(1);
                    end
                end
                S_PLACE: begin
                    board_q    <= placed;
                    nb_q       <= '0;
                    ok_q       <= 1'b1;
                    land_out_q <= land_q;
                    rd_q       <= ROW_W'(ROWS - 1);
                    wr_q       <= ROW_W'(ROWS - 1);
                end
                S_CLEAR: begin
                    // Kept rows compact downward; rows never written stay zero.
                    if (row_full) begin
                        lines_q <= lines_q + 3'd1;
                    end else begin
                        nb_q <= nb_wr;
                        wr_q <= wr_q - ROW_W'(1);
                    end
                    rd_q <= rd_q - ROW_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.rsp_ok       = ok_q;
    assign bus.rsp_board    = nb_q;
    assign bus.rsp_land_row = land_out_q;
    assign bus.rsp_lines    = lines_q;

endmodule

// File: tb/tb_board_dropsim_seq.sv
// Directed bench for board_dropsim_seq.
// Hand-computed vectors checked with immediate assertions.
module tb_board_dropsim_seq;

    localparam int ROWS  = 20;
    localparam int COLS  = 10;
    localparam int ROW_W = 5;
    localparam int COL_W = 4;
    localparam int BW    = ROWS * COLS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    board_dropsim_seq_if #(
        .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W)
    ) bus ();

    board_dropsim_seq #(
        .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag,
                       input logic [BW-1:0] obs,
                       input logic [BW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] p,
                        input logic [COL_W-1:0] c,
                        input logic [BW-1:0] b);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_piece = p;
        bus.req_col   = c;
        bus.req_board = b;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // n counts negedges from the one after the accepting edge (n=1).
    task automatic wait_rsp(input string tag, output int n,
                            output logic rdy_seen);
        n = 1;
        rdy_seen = bus.req_ready;
        while (!bus.rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
            rdy_seen = rdy_seen | bus.req_ready;
        end
        chk({tag, "_rsp_valid"}, BW'(bus.rsp_valid), BW'(1));
    endtask

    task automatic ack(input string tag);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({tag, "_idle_ready"}, BW'(bus.req_ready), BW'(1));
        chk({tag, "_idle_valid"}, BW'(bus.rsp_valid), BW'(0));
    endtask

    task automatic chk_rsp(input string tag, input logic ok,
                           input logic [BW-1:0] b,
                           input logic [ROW_W-1:0] land,
                           input logic [2:0] lines);
        chk({tag, "_ok"},    BW'(bus.rsp_ok), BW'(ok));
        chk({tag, "_board"}, bus.rsp_board, b);
        chk({tag, "_land"},  BW'(bus.rsp_land_row), BW'(land));
        chk({tag, "_lines"}, BW'(bus.rsp_lines), BW'(lines));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [BW-1:0] b;
        logic [BW-1:0] e;
        logic [BW-1:0] held;
        logic          rdy;
        logic          stable;
        logic          seen;
        int            n;

        bus.req_valid = 1'b0;
        bus.req_piece = '0;
        bus.req_col   = '0;
        bus.req_board = '0;
        bus.rsp_ready = 1'b0;

        // Reset values
        #12;
        chk("rst_req_ready", BW'(bus.req_ready), BW'(1));
        chk("rst_rsp_valid", BW'(bus.rsp_valid), BW'(0));
        chk_rsp("rst", 1'b0, '0, '0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: O piece on empty board lands on row 18
        b = '0;
        e = '0;
        e[180] = 1'b1; e[181] = 1'b1; e[190] = 1'b1; e[191] = 1'b1;
        send(16'h0033, 4'd0, b);
        wait_rsp("t1", n, rdy);
        chk("t1_busy_ready", BW'(rdy), BW'(0));
        chk_rsp("t1", 1'b1, e, 5'd18, 3'd0);
        ack("t1");

        // 2: bar completes row 19; ready already high on first DONE cycle
        b = '0;
        for (int c = 4; c < COLS; c++) b[19*COLS + c] = 1'b1;
        bus.rsp_ready = 1'b1;
        send(16'h000F, 4'd0, b);
        wait_rsp("t2", n, rdy);
        chk_rsp("t2", 1'b1, '0, 5'd19, 3'd1);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("t2_one_cycle_done", BW'(bus.rsp_valid), BW'(0));
        chk("t2_back_idle", BW'(bus.req_ready), BW'(1));

        // 3: collision at y=0 is illegal, board echoed
        b = '0;
        b[5] = 1'b1;
        send(16'h000F, 4'd3, b);
        wait_rsp("t3", n, rdy);
        chk_rsp("t3", 1'b0, b, 5'd0, 3'd0);
        ack("t3");

        // 4: out of bounds at col 8, two-cycle latency
        b = '0;
        send(16'h000F, 4'd8, b);
        wait_rsp("t4", n, rdy);
        chk("t4_latency", BW'(n), BW'(2));
        chk_rsp("t4", 1'b0, '0, 5'd0, 3'd0);
        ack("t4");

        // 5: back-pressure; a stray request during busy must be ignored
        b = '0;
        e = '0;
        e[180] = 1'b1; e[181] = 1'b1; e[190] = 1'b1; e[191] = 1'b1;
        send(16'h0033, 4'd0, b);
        bus.req_valid = 1'b1;
        bus.req_piece = 16'h000F;
        bus.req_col   = 4'd2;
        bus.req_board = '1;
        wait_rsp("t5", n, rdy);
        chk("t5_busy_ready", BW'(rdy), BW'(0));
        held   = bus.rsp_board;
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
                bus.rsp_board !== held || bus.rsp_ok !== 1'b1 ||
                bus.rsp_land_row !== 5'd18 || bus.rsp_lines !== 3'd0)
                stable = 1'b0;
        end
        chk("t5_stable", BW'(stable), BW'(1));
        chk_rsp("t5", 1'b1, e, 5'd18, 3'd0);
        bus.req_valid = 1'b0;
        ack("t5");

        // 6: reset during SCAN discards the transaction
        send(16'h0033, 4'd0, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", BW'(bus.req_ready), BW'(1));
        chk("t6_rst_valid", BW'(bus.rsp_valid), BW'(0));
        chk_rsp("t6_rst", 1'b0, '0, '0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid;
        end
        chk("t6_no_rsp", BW'(seen), BW'(0));
        b = '0;
        b[5] = 1'b1;
        send(16'h000F, 4'd3, b);
        wait_rsp("t6b", n, rdy);
        chk_rsp("t6b", 1'b0, b, 5'd0, 3'd0);
        ack("t6b");

        // 7: vertical bar in col 9 clears four rows
        b = '0;
        for (int r = 16; r < ROWS; r++)
            for (int c = 0; c < 9; c++) b[r*COLS + c] = 1'b1;
        send(16'h1111, 4'd9, b);
        wait_rsp("t7", n, rdy);
        chk_rsp("t7", 1'b1, '0, 5'd16, 3'd4);
        ack("t7");

        // 8: row above a cleared row shifts down
        b = '0;
        for (int c = 1; c < COLS; c++) b[19*COLS + c] = 1'b1;
        b[18*COLS + 5] = 1'b1;
        e = '0;
        e[19*COLS + 5] = 1'b1;
        send(16'h0001, 4'd0, b);
        wait_rsp("t8", n, rdy);
        chk_rsp("t8", 1'b1, e, 5'd19, 3'd1);
        ack("t8");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
